// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: decode-side stall/redirect inputs, instruction ROM port and IF/ID output.
// The if_adel_o signal exists only when IMEM_ALIGN_CHECK_EN is defined.
interface inst_fetch_if;
  logic        stall_i;
  logic [32:0] id_jump_i;     // {en, addr[31:0]}
  logic        imem_ce_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [63:0] if_inst_o;     // {addr[31:0], data[31:0]}
  logic        if_valid_o;
`ifdef IMEM_ALIGN_CHECK_EN
  logic        if_adel_o;
`endif

  modport master (
    input  stall_i, id_jump_i, imem_rdata_i,
    output imem_ce_o, imem_addr_o, if_inst_o, if_valid_o
`ifdef IMEM_ALIGN_CHECK_EN
    , output if_adel_o
`endif
  );

  modport slave (
    output stall_i, id_jump_i, imem_rdata_i,
    input  imem_ce_o, imem_addr_o, if_inst_o, if_valid_o
`ifdef IMEM_ALIGN_CHECK_EN
    , input if_adel_o
`endif
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous ROM, applies decode redirects
// and freezes its output across stalls. IMEM_ALIGN_CHECK_EN adds misaligned-fetch flagging.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_vld_q, req_vld_d;
  logic [63:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;

  logic        take_jump;
  logic        issue;
  logic        misalign;
  logic [31:0] fetch_addr;
  logic [31:0] run_data;
  logic [63:0] run_inst;

  logic        ce_o, valid_o, adel_o;
  logic [31:0] addr_o;
  logic [63:0] inst_o;

`ifdef IMEM_ALIGN_CHECK_EN
  logic req_adel_q, req_adel_d;
  logic hold_adel_q, hold_adel_d;
  assign misalign = |fetch_addr[1:0];
`else
  logic req_adel_q, hold_adel_q;
  assign misalign    = 1'b0;
  assign req_adel_q  = 1'b0;
  assign hold_adel_q = 1'b0;
`endif

  // Redirects are only honoured on cycles that actually issue a request.
  assign take_jump  = bus.id_jump_i[32] & ~bus.stall_i;
  assign fetch_addr = take_jump ? bus.id_jump_i[31:0] : pc_q;
  assign issue      = ~bus.stall_i;

  // A flagged misaligned fetch emerges as a NOP with its address preserved.
  assign run_data = (req_vld_q & ~req_adel_q) ? bus.imem_rdata_i : 32'h0;
  assign run_inst = {req_addr_q, run_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'h0;
      req_vld_q  <= 1'b0;
      hold_q     <= 64'h0;
      hold_vld_q <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
      req_adel_q  <= 1'b0;
      hold_adel_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_vld_q  <= req_vld_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`ifdef IMEM_ALIGN_CHECK_EN
      req_adel_q  <= req_adel_d;
      hold_adel_q <= hold_adel_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    req_vld_d  = req_vld_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`ifdef IMEM_ALIGN_CHECK_EN
    req_adel_d  = req_adel_q;
    hold_adel_d = hold_adel_q;
`endif
    if (issue) begin
      pc_d       = fetch_addr + PC_STEP;
      req_addr_d = fetch_addr;
      req_vld_d  = 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
      req_adel_d = misalign;
`endif
    end
    case (state_q)
      BOOT: if (issue) state_d = RUN;
      RUN: begin
        if (!issue) begin
          state_d    = HOLD;
          hold_d     = run_inst;
          hold_vld_d = req_vld_q;
`ifdef IMEM_ALIGN_CHECK_EN
          hold_adel_d = req_adel_q;
`endif
        end
      end
      HOLD: if (issue) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    ce_o    = 1'b0;
    addr_o  = 32'h0;
    inst_o  = 64'h0;
    valid_o = 1'b0;
    adel_o  = 1'b0;
    if (!rst) begin
      if (issue && !misalign) begin
        ce_o   = 1'b1;
        addr_o = fetch_addr;
      end
      case (state_q)
        RUN: begin
          inst_o  = run_inst;
          valid_o = req_vld_q;
          adel_o  = req_adel_q;
        end
        HOLD: begin
          inst_o  = hold_q;
          valid_o = hold_vld_q;
          adel_o  = hold_adel_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_ce_o   = ce_o;
  assign bus.imem_addr_o = addr_o;
  assign bus.if_inst_o   = inst_o;
  assign bus.if_valid_o  = valid_o;
`ifdef IMEM_ALIGN_CHECK_EN
  assign bus.if_adel_o   = adel_o;
`else
  logic unused_adel;
  assign unused_adel = adel_o;
`endif
endmodule
